wb_clint: RTL

//   Wishbone classic responder implementing the RISC-V machine timer and software interrupt (CLINT subset).

---
 rtl/wb_clint_pkg.sv | 46 ++++
 rtl/wb_clint_timer.sv | 71 +++++++
 rtl/wb_clint.sv | 121 ++++++++++++
 3 files changed

// File: rtl/wb_clint_pkg.sv
// Shared CLINT register offsets, reset constants and helpers for the
// Wishbone machine-timer / software-interrupt block.
package wb_clint_pkg;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } reg_sel_e;

  // Word offset (addr[15:2]) to register select; byte lane bits are ignored.
  function automatic reg_sel_e decode_offset(input logic [13:0] word);
    reg_sel_e r;
    case (word)
      CLINT_MSIP[15:2]:        r = REG_MSIP;
      CLINT_MTIMECMP_LO[15:2]: r = REG_CMP_LO;
      CLINT_MTIMECMP_HI[15:2]: r = REG_CMP_HI;
      CLINT_MTIME_LO[15:2]:    r = REG_TIME_LO;
      CLINT_MTIME_HI[15:2]:    r = REG_TIME_HI;
      default:                 r = REG_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : old_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_clint_timer.sv
// Prescaled 64-bit mtime counter, mtimecmp register with byte-lane writes,
// and the registered timer-interrupt compare.
module clint_timer
  import wb_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  reg_sel_e    reg_sel_i,
  input  logic [31:0] wdat_i,
  input  logic [3:0]  sel_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o,
  output logic        mtip_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          mtip_q, mtip_d;
  logic          tick;

  always_comb begin
    tick       = (presc_q == PRESC_MAX);
    presc_d    = tick ? '0 : presc_q + PW'(1);
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;

    // A write to either mtime half wins over the tick; the increment is lost.
    if (wr_en_i && reg_sel_i == REG_TIME_LO) begin
      mtime_d[31:0] = merge_bytes(mtime_q[31:0], wdat_i, sel_i);
    end else if (wr_en_i && reg_sel_i == REG_TIME_HI) begin
      mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdat_i, sel_i);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr_en_i && reg_sel_i == REG_CMP_LO) begin
      mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], wdat_i, sel_i);
    end
    if (wr_en_i && reg_sel_i == REG_CMP_HI) begin
      mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdat_i, sel_i);
    end

    mtip_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      mtip_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= mtip_d;
    end
  end

  assign mtime_o    = mtime_q;
  assign mtimecmp_o = mtimecmp_q;
  assign mtip_o     = mtip_q;

endmodule

// File: rtl/wb_clint.sv
// Wishbone classic responder for the RISC-V CLINT subset: msip, mtimecmp and
// mtime, with one registered ack/err pulse per request.
module wb_clint
  import wb_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic        msip_q, msip_d;

  logic        req;
  logic        in_window;
  reg_sel_e    reg_sel;
  logic        hit;
  logic        wr_en;
  logic [31:0] rd_data;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        unused_addr;

  assign unused_addr = ^wbs_addr_i[1:0];

  assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q & ~err_q;
  assign in_window = (wbs_addr_i[31:16] == BASE_ADDR[31:16]);
  assign reg_sel   = in_window ? decode_offset(wbs_addr_i[15:2]) : REG_NONE;
  assign hit       = (reg_sel != REG_NONE);
  assign wr_en     = req & wbs_we_i & hit;

  clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en),
    .reg_sel_i  (reg_sel),
    .wdat_i     (wbs_dat_i),
    .sel_i      (wbs_sel_i),
    .mtime_o    (mtime),
    .mtimecmp_o (mtimecmp),
    .mtip_o     (xint_mtip_o)
  );

  always_comb begin
    case (reg_sel)
      REG_MSIP:    rd_data = {31'd0, msip_q};
      REG_CMP_LO:  rd_data = mtimecmp[31:0];
      REG_CMP_HI:  rd_data = mtimecmp[63:32];
      REG_TIME_LO: rd_data = mtime[31:0];
      REG_TIME_HI: rd_data = mtime[63:32];
      default:     rd_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    msip_d  = msip_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_RESP;
          if (hit) begin
            ack_d = 1'b1;
            if (!wbs_we_i) dat_d = rd_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (wr_en && reg_sel == REG_MSIP && wbs_sel_i[0]) msip_d = wbs_dat_i[0];
  end

  // Reset also drops any response in flight; the master has to retry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'd0;
      msip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      msip_q  <= msip_d;
    end
  end

  assign wbs_dat_o   = dat_q;
  assign wbs_ack_o   = ack_q;
  assign wbs_err_o   = err_q;
  assign xint_msip_o = msip_q;

endmodule
